// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path: byte width and the default
// buffer geometry used by uart_rx_fifo.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W             = 8;
    localparam int UART_DEFAULT_DEPTH      = 16;
    localparam int UART_DEFAULT_RTS_THRESH = 4;

endpackage : uart_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH storage array for a FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset. Kept generic so
// a transmit-side FIFO can share it.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : sync_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive byte buffer between uart_rx and the Z80 I/O register logic. Bytes
// arrive and leave through level-held ready/clear handshakes; up to DEPTH
// bytes are queued so bursts are not lost while the CPU is busy.
//
// Optional feature: define UART_RX_FIFO_RTS_EN to add the registered rts_n
// flow-control output (asserts high when free entries <= RTS_THRESH).
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   in_data    in   byte from uart_rx
//   in_valid   in   uart_rx data ready (level, held until acknowledged)
//   in_clear   out  acknowledge back to uart_rx (level)
//   out_data   out  head byte, valid while out_ready
//   out_ready  out  FIFO not empty
//   out_clear  in   consumer pop request, acted on at its rising edge
//   count      out  occupancy, 0..DEPTH
//   overflow   out  sticky: a byte was dropped while full
//   ovf_clear  in   clears overflow (a same-cycle drop wins)
//   rts_n      out  host flow control (only with UART_RX_FIFO_RTS_EN)
//
// Ingress FSM
//   state   | meaning
//   IDLE    | waiting for in_valid; a byte is stored or dropped on entry to ACK
//   ACK     | in_clear high; waiting for uart_rx to drop in_valid
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_DEFAULT_DEPTH,
    parameter int RTS_THRESH = UART_DEFAULT_RTS_THRESH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_clear,
    output logic [UART_BYTE_W-1:0] out_data,
    output logic                   out_ready,
    input  logic                   out_clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clear
`ifdef UART_RX_FIFO_RTS_EN
   ,output logic                   rts_n
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        RTS_THRESH < 0 || RTS_THRESH > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..256 and RTS_THRESH in 0..DEPTH");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ing_state_t;

    ing_state_t     state_q, state_d;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_q;
    logic           out_clear_q;
    logic           full;
    logic           push, drop, pop;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        drop     = 1'b0;
        in_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Fullness is judged before any same-cycle pop, so a pop
                    // never makes room for a byte arriving in that cycle.
                    push    = ~full;
                    drop    = full;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                in_clear = 1'b1;
                if (!in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One pop per rising edge of out_clear; a held request does nothing more.
    assign pop = out_clear & ~out_clear_q & (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_clear_q <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_clear_q <= out_clear;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    assign count     = count_q;
    assign out_ready = (count_q != '0);

`ifdef UART_RX_FIFO_RTS_EN
    logic [CW-1:0] free_cnt;

    assign free_cnt = CW'(DEPTH) - count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rts_n <= 1'b0;
        end else begin
            rts_n <= (free_cnt <= CW'(RTS_THRESH));
        end
    end
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH=16, RTS_THRESH=4). A queue-based
// reference model tracks the expected contents, handshake and flags every
// cycle; a vector table and hand-written sequences cover the named cases.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH      = 16;
    localparam int RTS_THRESH = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_clear;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          out_clear;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clear;
`ifdef UART_RX_FIFO_RTS_EN
    logic          rts_n;
`endif

    uart_rx_fifo #(
        .DEPTH      (DEPTH),
        .RTS_THRESH (RTS_THRESH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_clear  (in_clear),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_clear (out_clear),
        .count     (count),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
`ifdef UART_RX_FIFO_RTS_EN
       ,.rts_n     (rts_n)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    byte unsigned mq[$];
    bit           m_busy;      // producer's byte handled, awaiting its release
    bit           m_ovf;
    bit           m_prev_clr;
    bit           m_rts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare every output against it.
    task automatic step(input string tag);
        int sz;
        bit do_push, do_drop, do_pop;
        sz      = mq.size();
        do_push = 1'b0;
        do_drop = 1'b0;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_busy     = 1'b0;
            m_ovf      = 1'b0;
            m_prev_clr = 1'b0;
            m_rts      = 1'b0;
        end else begin
            m_rts = ((DEPTH - sz) <= RTS_THRESH);
            if (!m_busy && in_valid) begin
                if (sz == DEPTH) do_drop = 1'b1;
                else             do_push = 1'b1;
                m_busy = 1'b1;
            end else if (m_busy && !in_valid) begin
                m_busy = 1'b0;
            end
            do_pop = out_clear && !m_prev_clr && (sz != 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
            if (do_drop)        m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
            m_prev_clr = out_clear;
        end
        #1;
        check({tag, ".count"},     32'(count),     32'(mq.size()));
        check({tag, ".out_ready"}, 32'(out_ready), 32'(mq.size() != 0));
        check({tag, ".in_clear"},  32'(in_clear),  32'(m_busy));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        if (mq.size() != 0) begin
            check({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
        end
`ifdef UART_RX_FIFO_RTS_EN
        check({tag, ".rts_n"}, 32'(rts_n), 32'(m_rts));
`endif
    endtask

    task automatic push_byte(input logic [7:0] b, input string tag);
        in_valid = 1'b1;
        in_data  = b;
        step(tag);
        in_valid = 1'b0;
        step(tag);
    endtask

    task automatic pop_byte(input string tag);
        out_clear = 1'b1;
        step(tag);
        out_clear = 1'b0;
        step(tag);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       oc;
        logic       oclr;
        logic [4:0] e_cnt;
        logic       e_rdy;
        logic       e_clr;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h41, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h41, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h42, 1'b0};
        vecs[5]  = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h42, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h42, 1'b0};
        vecs[7]  = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 8'h42, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 8'h43, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 8'h43, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 8'h43, 1'b0};

        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_clear = 1'b0;
        ovf_clear = 1'b0;
        mq.delete();
        m_busy = 0; m_ovf = 0; m_prev_clr = 0; m_rts = 0;
        step("reset");
        step("reset");
        check("reset.count",     32'(count),     32'd0);
        check("reset.out_ready", 32'(out_ready), 32'd0);
        check("reset.in_clear",  32'(in_clear),  32'd0);
        check("reset.overflow",  32'(overflow),  32'd0);
`ifdef UART_RX_FIFO_RTS_EN
        check("reset.rts_n",     32'(rts_n),     32'd0);
`endif
        reset = 1'b0;

        // Single byte and handshake table
        for (int i = 0; i < 11; i++) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            out_clear = vecs[i].oc;
            ovf_clear = vecs[i].oclr;
            step("vec");
            check($sformatf("vec%0d.count", i),    32'(count),     32'(vecs[i].e_cnt));
            check($sformatf("vec%0d.ready", i),    32'(out_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d.in_clear", i), 32'(in_clear),  32'(vecs[i].e_clr));
            check($sformatf("vec%0d.overflow", i), 32'(overflow),  32'(vecs[i].e_ovf));
            if (vecs[i].e_rdy) begin
                check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
            end
        end
        in_valid  = 1'b0;
        out_clear = 1'b0;
        ovf_clear = 1'b0;
        pop_byte("drain");

        // Fill to DEPTH, overflow, set-wins-over-clear, ordered drain
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), "fill");
        check("fill.count", 32'(count), 32'(DEPTH));
        push_byte(8'hAA, "fill_ovf");
        check("fill_ovf.overflow", 32'(overflow), 32'd1);
        check("fill_ovf.count",    32'(count),    32'(DEPTH));
        in_valid  = 1'b1;
        in_data   = 8'hBB;
        ovf_clear = 1'b1;
        step("ovf_setwins");
        check("ovf_setwins.overflow", 32'(overflow), 32'd1);
        in_valid = 1'b0;
        step("ovf_clear");
        check("ovf_clear.overflow", 32'(overflow), 32'd0);
        ovf_clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("fill_order%0d", i), 32'(out_data), 32'(i));
            pop_byte("fill_pop");
        end
        check("fill_empty.count", 32'(count), 32'd0);

        // Held out_clear pops once
        for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i), "held");
        out_clear = 1'b1;
        repeat (10) step("held");
        out_clear = 1'b0;
        step("held");
        check("held.count",    32'(count),    32'd2);
        check("held.out_data", 32'(out_data), 32'h62);
        pop_byte("held_drain");
        pop_byte("held_drain");

        // Simultaneous push and pop at count 5
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i), "simul");
        in_valid  = 1'b1;
        in_data   = 8'h75;
        out_clear = 1'b1;
        step("simul");
        check("simul.count",    32'(count),    32'd5);
        check("simul.out_data", 32'(out_data), 32'h71);
        in_valid  = 1'b0;
        out_clear = 1'b0;
        step("simul");
        for (int i = 0; i < 5; i++) pop_byte("simul_drain");

`ifdef UART_RX_FIFO_RTS_EN
        for (int i = 0; i < 11; i++) push_byte(8'h30 + 8'(i), "rts");
        check("rts.at11", 32'(rts_n), 32'd0);
        push_byte(8'h3B, "rts");
        check("rts.at12", 32'(rts_n), 32'd1);
        pop_byte("rts");
        check("rts.after_pop", 32'(rts_n), 32'd0);
        for (int i = 0; i < 11; i++) pop_byte("rts_drain");
`endif

        // Interleaved 40 bytes across several pointer wraps
        begin
            int popped = 0;
            for (int i = 0; i < 40; i++) begin
                push_byte(8'h80 + 8'(i), "wrap");
                if (i >= 3) begin
                    check("wrap.order", 32'(out_data), 32'(8'h80 + 8'(popped)));
                    pop_byte("wrap");
                    popped++;
                end
            end
            while (popped < 40) begin
                check("wrap.order", 32'(out_data), 32'(8'h80 + 8'(popped)));
                pop_byte("wrap");
                popped++;
            end
            check("wrap.count", 32'(count), 32'd0);
        end

        // Reset while acknowledging: the still-held byte is taken again
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step("midrst");
        reset = 1'b1;
        step("midrst");
        check("midrst.in_clear", 32'(in_clear), 32'd0);
        check("midrst.count",    32'(count),    32'd0);
        reset = 1'b0;
        step("midrst");
        check("midrst.reaccept",  32'(count),     32'd1);
        check("midrst.data",      32'(out_data),  32'h5A);
        in_valid = 1'b0;
        step("midrst");
        pop_byte("midrst");

        // Randomized traffic: a fill-heavy phase, then a drain-heavy phase
        for (int ph = 0; ph < 2; ph++) begin
            int p_in  = (ph == 0) ? 70 : 25;
            int p_tog = (ph == 0) ? 15 : 50;
            for (int c = 0; c < 250; c++) begin
                if (in_valid && m_busy) begin
                    in_valid = 1'b0;
                end else if (!in_valid && ($urandom_range(0, 99) < p_in)) begin
                    in_valid = 1'b1;
                    in_data  = 8'($urandom);
                end
                if ($urandom_range(0, 99) < p_tog) out_clear = ~out_clear;
                ovf_clear = ($urandom_range(0, 99) < 3);
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
